// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg
// Shared types and constants for the data-memory arbiter and its helpers.
//   state_t       : arbiter sequencing states
//   req_t         : one requester's command (we, be, byte addr, wdata)
//   BE_FULL       : byte-enable pattern for a whole-word store
//   DM_MEM_WORDS  : default number of words in dm
package dm_arb_pkg;

    localparam int DM_MEM_WORDS = 3072;

    localparam logic [3:0] BE_FULL = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MERGE,
        WRITE,
        RESP
    } state_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/dm_byte_merge.sv
// dm_byte_merge
// Combines an existing memory word with new byte-lane data.
//   old_word : word currently held in memory
//   new_word : byte-lane aligned store data
//   be       : byte enables; lane i taken from new_word when be[i]=1
//   merged   : resulting word to write back
module dm_byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  be,
    output logic [31:0] merged
);

    // Start from the old word and overlay each enabled lane.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter
// Shares the word-addressed data memory between the MEM stage (port 0) and
// the debug/loader bridge (port 1). One access in flight, round-robin grant
// on contention, sub-word stores done as read-modify-write.
//   clk, reset                  : clock, synchronous active-low reset
//   reqN_valid/we/be/addr/wdata : request from requester N
//   reqN_ready                  : request accepted this cycle
//   reqN_rvalid/rdata/err       : one-cycle response to requester N
//   mem_addr/we/wdata           : dm word address, write strobe, write data
//   mem_full_addr               : word-aligned byte address for dm trace
//   mem_rdata                   : dm combinational read data
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int MEM_WORDS = DM_MEM_WORDS,
    parameter int AW        = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic          req0_we,
    input  logic [3:0]    req0_be,
    input  logic [31:0]   req0_addr,
    input  logic [31:0]   req0_wdata,
    output logic          req0_ready,
    output logic          req0_rvalid,
    output logic [31:0]   req0_rdata,
    output logic          req0_err,
    input  logic          req1_valid,
    input  logic          req1_we,
    input  logic [3:0]    req1_be,
    input  logic [31:0]   req1_addr,
    input  logic [31:0]   req1_wdata,
    output logic          req1_ready,
    output logic          req1_rvalid,
    output logic [31:0]   req1_rdata,
    output logic          req1_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    output logic [31:0]   mem_full_addr,
    input  logic [31:0]   mem_rdata
);

    localparam logic [AW:0] MEM_LIMIT = (AW+1)'(MEM_WORDS);

    state_t        state;
    logic          rr;
    logic          owner;
    logic          lat_we;
    logic [3:0]    lat_be;
    logic [AW-1:0] lat_addr;
    logic [31:0]   lat_data;
    logic          lat_err;

    logic          grant_any;
    logic          grant_sel;
    req_t          in_req;
    logic          in_oor;
    state_t        accept_next;
    logic [31:0]   merged;
    logic          unused_addr_lsbs;

    // Pick the requester to grant and mux its command; the rr pointer only
    // matters when both are asking at once.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_sel = (req0_valid && req1_valid) ? rr : req1_valid;
        if (grant_sel) begin
            in_req.we    = req1_we;
            in_req.be    = req1_be;
            in_req.addr  = req1_addr;
            in_req.wdata = req1_wdata;
        end else begin
            in_req.we    = req0_we;
            in_req.be    = req0_be;
            in_req.addr  = req0_addr;
            in_req.wdata = req0_wdata;
        end
    end

    // Range check plus first state after acceptance. Empty-mask writes and
    // out-of-range requests go straight to the response without touching dm.
    always_comb begin
        in_oor = (in_req.addr[31:AW+2] != '0) ||
                 ({1'b0, in_req.addr[AW+1:2]} >= MEM_LIMIT);
        if (in_oor) begin
            accept_next = RESP;
        end else if (!in_req.we) begin
            accept_next = READ;
        end else if (in_req.be == BE_FULL) begin
            accept_next = WRITE;
        end else if (in_req.be == 4'b0000) begin
            accept_next = RESP;
        end else begin
            accept_next = MERGE;
        end
    end

    assign unused_addr_lsbs = ^in_req.addr[1:0];

    dm_byte_merge u_merge (
        .old_word (mem_rdata),
        .new_word (lat_data),
        .be       (lat_be),
        .merged   (merged)
    );

    // Sequencer. lat_data holds the store data on accept (zero for reads),
    // then the read word or the merged word, so one register feeds both
    // mem_wdata and the response data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            rr       <= 1'b0;
            owner    <= 1'b0;
            lat_we   <= 1'b0;
            lat_be   <= 4'b0000;
            lat_addr <= '0;
            lat_data <= 32'h0;
            lat_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner    <= grant_sel;
                        lat_we   <= in_req.we;
                        lat_be   <= in_req.be;
                        lat_addr <= in_req.addr[AW+1:2];
                        lat_data <= in_req.we ? in_req.wdata : 32'h0;
                        lat_err  <= in_oor;
                        state    <= accept_next;
                    end
                end
                READ: begin
                    lat_data <= mem_rdata;
                    state    <= RESP;
                end
                MERGE: begin
                    lat_data <= merged;
                    state    <= WRITE;
                end
                WRITE: begin
                    state <= RESP;
                end
                RESP: begin
                    rr    <= ~owner;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs follow the registered state; everything is forced low while
    // reset is held so nothing leaks out of a half-finished access.
    always_comb begin
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        req0_rvalid = 1'b0;
        req1_rvalid = 1'b0;
        req0_rdata  = 32'h0;
        req1_rdata  = 32'h0;
        req0_err    = 1'b0;
        req1_err    = 1'b0;
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_wdata   = 32'h0;
        if (reset) begin
            req0_ready = (state == IDLE) && grant_any && !grant_sel;
            req1_ready = (state == IDLE) && grant_any && grant_sel;
            case (state)
                READ, MERGE: begin
                    mem_addr = lat_addr;
                end
                WRITE: begin
                    mem_addr  = lat_addr;
                    mem_we    = 1'b1;
                    mem_wdata = lat_data;
                end
                RESP: begin
                    if (owner) begin
                        req1_rvalid = 1'b1;
                        req1_rdata  = lat_we ? 32'h0 : lat_data;
                        req1_err    = lat_err;
                    end else begin
                        req0_rvalid = 1'b1;
                        req0_rdata  = lat_we ? 32'h0 : lat_data;
                        req0_err    = lat_err;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_full_addr = {{(30-AW){1'b0}}, mem_addr, 2'b00};

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter
// Bench for dm_arbiter: a behavioural dm, a reference memory plus
// arbitration model, and a scoreboard of expected responses and memory
// accesses that a separate monitor retires as the DUT produces them.
module tb_dm_arbiter;

    localparam int MEM_WORDS = 3072;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_we, req0_ready, req0_rvalid, req0_err;
    logic [3:0]  req0_be;
    logic [31:0] req0_addr, req0_wdata, req0_rdata;
    logic        req1_valid, req1_we, req1_ready, req1_rvalid, req1_err;
    logic [3:0]  req1_be;
    logic [31:0] req1_addr, req1_wdata, req1_rdata;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata, mem_full_addr, mem_rdata;

    dm_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req0_we       (req0_we),
        .req0_be       (req0_be),
        .req0_addr     (req0_addr),
        .req0_wdata    (req0_wdata),
        .req0_ready    (req0_ready),
        .req0_rvalid   (req0_rvalid),
        .req0_rdata    (req0_rdata),
        .req0_err      (req0_err),
        .req1_valid    (req1_valid),
        .req1_we       (req1_we),
        .req1_be       (req1_be),
        .req1_addr     (req1_addr),
        .req1_wdata    (req1_wdata),
        .req1_ready    (req1_ready),
        .req1_rvalid   (req1_rvalid),
        .req1_rdata    (req1_rdata),
        .req1_err      (req1_err),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_full_addr (mem_full_addr),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural dm: combinational read, whole-word write on the edge.
    logic [31:0] dm      [0:MEM_WORDS-1];
    logic [31:0] ref_mem [0:MEM_WORDS-1];

    assign mem_rdata = (int'(mem_addr) < MEM_WORDS) ? dm[mem_addr] : 32'h0;

    always @(posedge clk) begin
        if (mem_we && int'(mem_addr) < MEM_WORDS) dm[mem_addr] = mem_wdata;
    end

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [11:0] addr;
        logic        we;
        logic [31:0] data;
        int          cyc;
    } acc_t;

    resp_t sb[$];
    acc_t  aq[$];
    int    grant_log[$];

    int checks = 0;
    int errors = 0;

    bit          pend   [2];
    logic        pwe    [2];
    logic [3:0]  pbe    [2];
    logic [31:0] paddr  [2];
    logic [31:0] pwdata [2];

    int rr_model   = 0;
    int resp_cycle = -1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic noteFail(input string name, input string what);
        checks++;
        errors++;
        $display("[TB] FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    task automatic applyStimulus(input int p, input logic we, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        pend[p]   = 1'b1;
        pwe[p]    = we;
        pbe[p]    = be;
        paddr[p]  = addr;
        pwdata[p] = wdata;
    endtask

    task automatic applyRandom(input int p);
        int          r;
        logic [3:0]  be;
        logic [31:0] addr;
        r = $urandom_range(0, 9);
        if (r == 0)     be = 4'h0;
        else if (r < 4) be = 4'hF;
        else            be = 4'($urandom_range(0, 15));
        r = $urandom_range(0, 9);
        if (r < 7)       addr = 32'($urandom_range(0, 31)) << 2;
        else if (r == 7) addr = 32'($urandom_range(3068, 3075)) << 2;
        else if (r == 8) addr = $urandom;
        else             addr = (32'($urandom_range(0, 31)) << 2) | (32'h1 << $urandom_range(14, 31));
        addr[1:0] = 2'($urandom_range(0, 3));
        applyStimulus(p, 1'($urandom_range(0, 1)), be, addr, $urandom);
    endtask

    // Reference model of one accepted request: latency and memory effect
    // come straight from the access type, not from any state sequence.
    task automatic modelAccept(input int p);
        logic [31:0] a;
        int          word;
        bit          oor;
        int          lat;
        logic [31:0] rd;
        logic [31:0] nw;
        acc_t        ac;
        resp_t       rs;
        a    = paddr[p];
        word = int'(a[13:2]);
        oor  = (a[31:14] != 18'h0) || (word >= MEM_WORDS);
        rd   = 32'h0;
        ac.addr = 12'(word);
        if (oor) begin
            lat = 1;
        end else if (!pwe[p]) begin
            lat = 2;
            rd  = ref_mem[word];
            ac.we = 1'b0; ac.data = 32'h0; ac.cyc = cyc + 1;
            aq.push_back(ac);
        end else if (pbe[p] == 4'hF) begin
            lat = 2;
            ref_mem[word] = pwdata[p];
            ac.we = 1'b1; ac.data = pwdata[p]; ac.cyc = cyc + 1;
            aq.push_back(ac);
        end else if (pbe[p] == 4'h0) begin
            lat = 1;
        end else begin
            lat = 3;
            nw  = ref_mem[word];
            for (int b = 0; b < 4; b++) begin
                if (pbe[p][b]) nw[8*b +: 8] = pwdata[p][8*b +: 8];
            end
            ref_mem[word] = nw;
            ac.we = 1'b0; ac.data = 32'h0; ac.cyc = cyc + 1;
            aq.push_back(ac);
            ac.we = 1'b1; ac.data = nw; ac.cyc = cyc + 2;
            aq.push_back(ac);
        end
        rs.port = p; rs.rdata = rd; rs.err = oor; rs.cyc = cyc + lat;
        sb.push_back(rs);
        resp_cycle = cyc + lat;
        rr_model   = p ^ 1;
    endtask

    // One cycle: drive pending requests, check ready against the model's
    // idea of who should be granted, record any acceptance.
    task automatic cycleStep();
        int g;
        @(negedge clk);
        req0_valid = pend[0]; req0_we = pwe[0]; req0_be = pbe[0];
        req0_addr  = paddr[0]; req0_wdata = pwdata[0];
        req1_valid = pend[1]; req1_we = pwe[1]; req1_be = pbe[1];
        req1_addr  = paddr[1]; req1_wdata = pwdata[1];
        #1;
        g = -1;
        if (cyc > resp_cycle) begin
            if (pend[0] && pend[1]) g = rr_model;
            else if (pend[0])       g = 0;
            else if (pend[1])       g = 1;
        end
        checkOutput("ready0", req0_ready, (g == 0));
        checkOutput("ready1", req1_ready, (g == 1));
        if (req0_ready && pend[0]) begin
            modelAccept(0); pend[0] = 1'b0; grant_log.push_back(0);
        end else if (req1_ready && pend[1]) begin
            modelAccept(1); pend[1] = 1'b0; grant_log.push_back(1);
        end
    endtask

    task automatic runIdle(input int maxc);
        int n;
        n = 0;
        while ((pend[0] || pend[1] || sb.size() != 0 || aq.size() != 0) && n < maxc) begin
            cycleStep();
            n++;
        end
        if (pend[0] || pend[1] || sb.size() != 0 || aq.size() != 0)
            noteFail("drain_timeout", "requests still outstanding");
    endtask

    // Hold reset for n cycles with both requesters asking, expecting all
    // outputs low; anything in flight is forgotten.
    task automatic doReset(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
            reset = 1'b0;
            sb.delete();
            aq.delete();
            req0_valid = 1'b1; req0_we = 1'b1; req0_be = 4'hF; req0_addr = 32'h10; req0_wdata = $urandom;
            req1_valid = 1'b1; req1_we = 1'b0; req1_be = 4'h3; req1_addr = 32'h14; req1_wdata = $urandom;
            #1;
            checkOutput("reset_ctrl", {req0_ready, req1_ready, req0_rvalid, req1_rvalid,
                                       req0_err, req1_err, mem_we}, 0);
            checkOutput("reset_mem_addr", mem_addr, 0);
            checkOutput("reset_mem_wdata", mem_wdata, 0);
            checkOutput("reset_rdata", {req0_rdata, req1_rdata}, 0);
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        rr_model   = 0;
        resp_cycle = -1;
        grant_log.delete();
        #1;
        checkOutput("post_reset_quiet", {mem_we, req0_rvalid, req1_rvalid}, 0);
    endtask

    resp_t mon_r;
    acc_t  mon_a;
    int    mon_p;

    // Monitor: retires expected memory accesses by cycle and expected
    // responses whenever an rvalid appears.
    always @(negedge clk) begin
        while (aq.size() != 0 && aq[0].cyc < cyc) begin
            void'(aq.pop_front());
            noteFail("missing_access", "expected dm access did not occur");
        end
        if (aq.size() != 0 && aq[0].cyc == cyc) begin
            mon_a = aq.pop_front();
            checkOutput("mem_addr", mem_addr, mon_a.addr);
            checkOutput("mem_we", mem_we, mon_a.we);
            if (mon_a.we) checkOutput("mem_wdata", mem_wdata, mon_a.data);
            checkOutput("mem_full_addr", mem_full_addr, {18'b0, mon_a.addr, 2'b00});
        end else if (mem_we) begin
            noteFail("unexpected_mem_we", $sformatf("addr %0h data %0h", mem_addr, mem_wdata));
        end
        while (sb.size() != 0 && sb[0].cyc < cyc) begin
            void'(sb.pop_front());
            noteFail("missing_rvalid", "expected response did not arrive");
        end
        if (req0_rvalid || req1_rvalid) begin
            checkOutput("single_rvalid", req0_rvalid & req1_rvalid, 0);
            if (sb.size() == 0) begin
                noteFail("unexpected_rvalid", $sformatf("rvalid0 %0b rvalid1 %0b", req0_rvalid, req1_rvalid));
            end else begin
                mon_r = sb.pop_front();
                mon_p = req0_rvalid ? 0 : 1;
                checkOutput("resp_port", mon_p, mon_r.port);
                checkOutput("resp_cycle", cyc, mon_r.cyc);
                checkOutput("rdata", mon_p ? req1_rdata : req0_rdata, mon_r.rdata);
                checkOutput("err", mon_p ? req1_err : req0_err, mon_r.err);
                checkOutput("other_port_quiet", mon_p ? {req0_err, req0_rdata} : {req1_err, req1_rdata}, 0);
            end
        end
    end

    logic [31:0] saved;

    initial begin
        reset = 1'b0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_be = 4'h0; req0_addr = 32'h0; req0_wdata = 32'h0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_be = 4'h0; req1_addr = 32'h0; req1_wdata = 32'h0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            dm[i]      = (32'(i) * 32'h01010101) ^ 32'hA5A50000;
            ref_mem[i] = dm[i];
        end
        dm[5]      = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;

        doReset(3);

        $display("[TB] directed accesses");
        applyStimulus(0, 1'b0, 4'h0, 32'h14, 32'h0);
        runIdle(20);
        applyStimulus(1, 1'b1, 4'hF, 32'h20, 32'h12345678);
        runIdle(20);
        applyStimulus(0, 1'b0, 4'h0, 32'h20, 32'h0);
        runIdle(20);
        applyStimulus(0, 1'b1, 4'b0010, 32'h20, 32'h0000AB00);
        runIdle(20);
        checkOutput("dm_word8_merged", dm[8], 32'h1234AB78);
        applyStimulus(1, 1'b1, 4'h0, 32'h24, 32'hFFFFFFFF);
        runIdle(20);
        applyStimulus(0, 1'b1, 4'hF, 32'h3000, 32'hCAFEF00D);
        runIdle(20);
        applyStimulus(0, 1'b1, 4'hF, 32'h0001_0000, 32'hCAFEF00D);
        runIdle(20);
        applyStimulus(1, 1'b0, 4'h0, 32'h2FFC, 32'h0);
        runIdle(20);

        $display("[TB] contention");
        doReset(2);
        for (int k = 0; k < 40; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) applyStimulus(p, 1'b0, 4'h0, 32'($urandom_range(0, 63)) << 2, 32'h0);
            end
            cycleStep();
        end
        runIdle(40);
        checkOutput("contention_grant_count", grant_log.size() >= 6, 1);
        for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
            checkOutput("contention_order", grant_log[k], k % 2);
        end

        $display("[TB] reset during read-modify-write");
        saved = ref_mem[8];
        applyStimulus(0, 1'b1, 4'b0100, 32'h20, 32'h00EE0000);
        for (int k = 0; k < 10 && pend[0]; k++) cycleStep();
        doReset(1);
        ref_mem[8] = saved;
        checkOutput("reset_mid_mem", dm[8], saved);
        applyStimulus(0, 1'b0, 4'h0, 32'h20, 32'h0);
        applyStimulus(1, 1'b0, 4'h0, 32'h14, 32'h0);
        cycleStep();
        checkOutput("grant_after_reset", req0_ready, 1);
        runIdle(20);

        $display("[TB] random traffic");
        for (int k = 0; k < 500; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 99) < 40) applyRandom(p);
            end
            cycleStep();
        end
        runIdle(60);
        repeat (3) @(negedge clk);
        checkOutput("sb_empty", sb.size(), 0);
        checkOutput("aq_empty", aq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
